mul_seq_ctrl: RTL

//   Sequential controller for a signed sign-magnitude shift-add multiplier.

---
 rtl/mul_seq_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Sequential controller for a signed shift-add multiplier working in
//   sign-magnitude form. One operand pair is accepted over a valid/ready
//   handshake, the multiplier magnitude is consumed one bit per clock into
//   an accumulator, and the 2*WIDTH-bit two's-complement product is offered
//   over a second valid/ready handshake.
//
// Parameters
//   WIDTH      operand width (two's complement); product is 2*WIDTH bits
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, aborts any operation
//   in_valid   operand pair a/b valid
//   in_ready   controller can accept operands (IDLE only)
//   a, b       multiplicand / multiplier, two's complement
//   out_valid  product valid (DONE only)
//   out_ready  consumer accepts product
//   out        registered product, two's complement
//   busy       high while calculating or holding a result
//
// Configuration
//   MUL_EARLY_TERM_EN  when defined, the calculation finishes as soon as
//                      the remaining multiplier bits are all zero instead
//                      of always taking WIDTH cycles.

module mul_seq_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic             sign;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    acc_mag;
  logic             last_step;

  // The most negative operand negates to itself in WIDTH bits, which read
  // as unsigned is exactly its magnitude 2^(WIDTH-1), so no extra bit needed.
  assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  assign partial = mb[0] ? ({{WIDTH{1'b0}}, ma} << cnt) : '0;
  assign acc_sum = acc + partial;
  // The magnitude never reaches the top bit, so clearing it is harmless and
  // guarantees the negation below always yields a valid signed result.
  assign acc_mag = {1'b0, acc_sum[PW-2:0]};

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after the one consumed now.
  assign last_step = (cnt == CW'(WIDTH - 1)) || (mb >> 1) == '0;
`else
  assign last_step = (cnt == CW'(WIDTH - 1));
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shift-add iteration and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ma   <= '0;
      mb   <= '0;
      sign <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ma   <= a_mag;
            mb   <= b_mag;
            sign <= a[WIDTH-1] ^ b[WIDTH-1];
            acc  <= '0;
            cnt  <= '0;
          end
        end
        CALC: begin
          acc <= acc_sum;
          mb  <= mb >> 1;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            out <= sign ? (~acc_mag + PW'(1)) : acc_mag;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
